// File: rtl/restador_serial_if.sv
// Bus between the control unit and the bit-serial subtractor.
// Handshake: the master raises start with a/b valid; the request is taken
// only on an edge where the slave is idle (state IDLE). busy is high while
// bits are being processed. done pulses for exactly one cycle, and
// diff/borrow/ovf are valid from that cycle until the next result.
// state is a read-only debug view of the slave FSM.
interface restador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic [1:0]       state;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, state
  );
endinterface

// File: rtl/restador_serial.sv
// Bit-serial full subtractor: a - b, LSB first, one bit per clock through
// a single full-subtractor cell with a registered borrow.
module restador_serial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  restador_serial_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;

  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             bout;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    a_i      = a_sh[0];
    b_i      = b_sh[0];
    d_i      = a_i ^ b_i ^ bin;
    bout     = (~a_i & b_i) | (~(a_i ^ b_i) & bin);
    res_next = {d_i, res[WIDTH-1:1]};
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      cnt        <= '0;
      bin        <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            res      <= '0;
            cnt      <= '0;
            bin      <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          res  <= res_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bout;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit: a_i/b_i are the operand sign bits, d_i the result sign.
            bus.diff   <= res_next;
            bus.borrow <= bout;
            bus.ovf    <= (a_i ^ b_i) & (d_i ^ a_i);
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.state = state;

endmodule
